// File: rtl/track_canvas_writer.sv
// track_canvas_writer: turns accepted mouse samples into brush-stamp writes on a 1-bit canvas RAM and sweeps the canvas clear on request
//
// Ports:
//   clka          system clock, all logic on the rising edge
//   rst           asynchronous reset, active low
//   sample_valid  mouse sample offered
//   sample_x/y    screen coordinates (0..639 / 0..479)
//   sample_ready  sample accepted when sample_valid & sample_ready
//   clear_req     request a full canvas clear (level or pulse)
//   clear_busy    clear sweep in progress
//   mem_we        canvas RAM write enable
//   mem_addr      canvas RAM address, cy*CANVAS_W + cx
//   mem_wdata     canvas RAM write data
//   dirty         at least one cell painted since the last completed clear
//
// Optional feature: define TRACK_DEDUP_EN to skip samples that land on the
// most recently stamped cell.
module track_canvas_writer #(
    parameter int CANVAS_W    = 160,
    parameter int CANVAS_H    = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int BRUSH_R     = 1,
    parameter int ADDR_W      = 15
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [9:0]        sample_x,
    input  logic [9:0]        sample_y,
    output logic              sample_ready,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wdata,
    output logic              dirty
);
    localparam int TOTAL = CANVAS_W * CANVAS_H;
    localparam int PW = ADDR_W + 11;
    localparam logic signed [10:0] CW = 11'(CANVAS_W);
    localparam logic signed [10:0] CH = 11'(CANVAS_H);
    localparam logic signed [10:0] R  = 11'(BRUSH_R);

    typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

    state_t state, state_next;
    logic signed [10:0] cx, cy, dx, dy, sx, sy, bx, by, ox, oy, tx, ty, nx, ny;
    logic [ADDR_W:0] clr_cnt;
    logic [ADDR_W-1:0] t_addr;
    logic stamp_done, accept, samp_in, is_dup, go_paint, t_in, last_off, clr_done;

    assign sample_ready = (state == IDLE) & ~clear_req;
    assign sx = {1'b0, sample_x >> SCALE_SHIFT};
    assign sy = {1'b0, sample_y >> SCALE_SHIFT};

`ifdef TRACK_DEDUP_EN
    logic signed [10:0] last_cx, last_cy;
    logic last_valid;

    assign is_dup = last_valid && sx == last_cx && sy == last_cy;

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            last_cx    <= '0;
            last_cy    <= '0;
            last_valid <= 1'b0;
        end else if (go_paint) begin
            last_cx    <= sx;
            last_cy    <= sy;
            last_valid <= 1'b1;
        end else if (state == CLEAR && clr_done) begin
            last_valid <= 1'b0;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    // The first stamp offset is issued on the accept edge straight from the
    // sample, so writes start the very next cycle; later offsets come from
    // the latched cell and the running dx/dy.
    always_comb begin
        accept     = sample_valid & sample_ready;
        samp_in    = sx < CW && sy < CH;
        go_paint   = accept & samp_in & ~is_dup;
        bx         = (state == PAINT) ? cx : sx;
        by         = (state == PAINT) ? cy : sy;
        ox         = (state == PAINT) ? dx : -R;
        oy         = (state == PAINT) ? dy : -R;
        tx         = bx + ox;
        ty         = by + oy;
        t_in       = !tx[10] && tx < CW && !ty[10] && ty < CH;
        t_addr     = ADDR_W'(PW'(ty) * PW'(CANVAS_W) + PW'(tx));
        last_off   = ox == R && oy == R;
        nx         = (ox == R) ? -R : ox + 11'sd1;
        ny         = (ox == R) ? oy + 11'sd1 : oy;
        clr_done   = clr_cnt == (ADDR_W + 1)'(TOTAL);
        state_next = (state == CLEAR) ? (clr_done ? IDLE : CLEAR)
                   : clear_req ? CLEAR
                   : (state == PAINT) ? (stamp_done ? IDLE : PAINT)
                   : go_paint ? PAINT : IDLE;
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            cx         <= '0;
            cy         <= '0;
            dx         <= '0;
            dy         <= '0;
            stamp_done <= 1'b0;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 1'b0;
            dirty      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (state != CLEAR && clear_req) begin
                clear_busy <= 1'b1;
                mem_we     <= 1'b1;
                mem_wdata  <= 1'b0;
                mem_addr   <= '0;
                clr_cnt    <= (ADDR_W + 1)'(1);
            end else if (state == CLEAR) begin
                if (clr_done) begin
                    clear_busy <= 1'b0;
                    dirty      <= 1'b0;
                end else begin
                    mem_we   <= 1'b1;
                    mem_addr <= clr_cnt[ADDR_W-1:0];
                    clr_cnt  <= clr_cnt + 1'b1;
                end
            end else if (go_paint || (state == PAINT && !stamp_done)) begin
                cx         <= bx;
                cy         <= by;
                dx         <= nx;
                dy         <= ny;
                stamp_done <= last_off;
                if (t_in) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= 1'b1;
                    mem_addr  <= t_addr;
                    dirty     <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_track_canvas_writer.sv
// tb_track_canvas_writer: directed self-checking bench for track_canvas_writer
module tb_track_canvas_writer;
    logic clka = 1'b0;
    logic rst = 1'b1;
    logic sample_valid = 1'b0, clear_req = 1'b0;
    logic [9:0] sample_x = '0, sample_y = '0;
    logic sample_ready, clear_busy, mem_we, mem_wdata, dirty;
    logic [14:0] mem_addr;

    logic v2 = 1'b0;
    logic [9:0] x2 = '0, y2 = '0;
    logic ready2, busy2, we2, wdata2, dirty2;
    logic [14:0] addr2;

    int total = 0, fails = 0;
    int ea[9];

    always #5 clka = ~clka;

    track_canvas_writer dut (
        .clka(clka), .rst(rst), .sample_valid(sample_valid), .sample_x(sample_x),
        .sample_y(sample_y), .sample_ready(sample_ready), .clear_req(clear_req),
        .clear_busy(clear_busy), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .dirty(dirty)
    );

    track_canvas_writer #(.CANVAS_W(100)) dut2 (
        .clka(clka), .rst(rst), .sample_valid(v2), .sample_x(x2),
        .sample_y(y2), .sample_ready(ready2), .clear_req(1'b0),
        .clear_busy(busy2), .mem_we(we2), .mem_addr(addr2),
        .mem_wdata(wdata2), .dirty(dirty2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one sample in cycle N; returns #1 into cycle N+1.
    task automatic offer(input int x, input int y);
        @(negedge clka);
        sample_valid = 1'b1;
        sample_x = 10'(x);
        sample_y = 10'(y);
        #1;
        chk("ready_on_offer", sample_ready, 1);
        @(negedge clka);
        sample_valid = 1'b0;
        #1;
    endtask

    // Checks cycles N+1..N+9 against a write pattern (MSB = first cycle) and
    // the addresses in ea[], then the idle cycle N+10.
    task automatic stamp(input string tag, input logic [8:0] we_pat);
        int j;
        j = 0;
        for (int k = 0; k < 9; k++) begin
            if (k == 0)
                chk({tag, "_busy_ready"}, sample_ready, 0);
            chk({tag, "_we"}, mem_we, we_pat[8-k]);
            if (we_pat[8-k]) begin
                chk({tag, "_addr"}, mem_addr, ea[j]);
                chk({tag, "_wdata"}, mem_wdata, 1);
                j++;
            end
            @(negedge clka);
            #1;
        end
        chk({tag, "_end_we"}, mem_we, 0);
        chk({tag, "_end_ready"}, sample_ready, 1);
        chk({tag, "_dirty"}, dirty, 1);
    endtask

    // Called #1 into the first clear cycle; pokes clear_req mid-sweep.
    task automatic run_clear(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 19200; i++) begin
            if (mem_we !== 1'b1 || mem_wdata !== 1'b0 || mem_addr !== 15'(i) || clear_busy !== 1'b1)
                bad++;
            if (i == 5000)
                clear_req = 1'b1;
            if (i == 5002)
                clear_req = 1'b0;
            @(negedge clka);
            #1;
        end
        chk({tag, "_sweep_errors"}, bad, 0);
        chk({tag, "_busy_after"}, clear_busy, 0);
        chk({tag, "_we_after"}, mem_we, 0);
        chk({tag, "_dirty_after"}, dirty, 0);
        chk({tag, "_ready_after"}, sample_ready, 1);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_dirty", dirty, 0);
        chk("rst_ready", sample_ready, 1);
        @(negedge clka);
        rst = 1'b1;

        ea = '{7864, 7865, 7866, 8024, 8025, 8026, 8184, 8185, 8186};
        offer(100, 200);
        stamp("mid", 9'h1FF);

        ea = '{0, 1, 160, 161, 0, 0, 0, 0, 0};
        offer(0, 0);
        stamp("corner", 9'b000011011);

        ea = '{19038, 19039, 19198, 19199, 0, 0, 0, 0, 0};
        offer(639, 479);
        stamp("far", 9'b110110000);

        @(negedge clka);
        v2 = 1'b1;
        x2 = 10'd500;
        y2 = 10'd10;
        #1;
        chk("oob_ready", ready2, 1);
        @(negedge clka);
        v2 = 1'b0;
        #1;
        chk("oob_we1", we2, 0);
        chk("oob_ready_after", ready2, 1);
        @(negedge clka);
        #1;
        chk("oob_we2", we2, 0);
        chk("oob_dirty", dirty2, 0);

        ea = '{7864, 7865, 7866, 8024, 8025, 8026, 8184, 8185, 8186};
        offer(101, 202);
        stamp("first", 9'h1FF);
`ifdef TRACK_DEDUP_EN
        offer(102, 203);
        chk("dup_we1", mem_we, 0);
        chk("dup_ready", sample_ready, 1);
        @(negedge clka);
        #1;
        chk("dup_we2", mem_we, 0);
`else
        offer(102, 203);
        stamp("repeat", 9'h1FF);
`endif

        @(negedge clka);
        clear_req = 1'b1;
        sample_valid = 1'b1;
        sample_x = 10'd40;
        sample_y = 10'd40;
        #1;
        chk("clr_ready", sample_ready, 0);
        chk("clr_dirty_before", dirty, 1);
        @(negedge clka);
        clear_req = 1'b0;
        sample_valid = 1'b0;
        #1;
        run_clear("clr");

        offer(101, 202);
        stamp("after_clear", 9'h1FF);

        offer(100, 200);
        @(negedge clka);
        #1;
        @(negedge clka);
        #1;
        chk("abort_third_addr", mem_addr, 7866);
        clear_req = 1'b1;
        @(negedge clka);
        clear_req = 1'b0;
        #1;
        run_clear("abort");

        offer(100, 200);
        @(negedge clka);
        #1;
        @(negedge clka);
        #1;
        chk("rstmid_we_before", mem_we, 1);
        rst = 1'b0;
        #1;
        chk("rstmid_we", mem_we, 0);
        chk("rstmid_dirty", dirty, 0);
        @(negedge clka);
        rst = 1'b1;
        #1;
        chk("rstmid_ready", sample_ready, 1);
        @(negedge clka);
        #1;
        chk("rstmid_we_after", mem_we, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
